uart_rx_fifo: RTL and testbench

//  UART receive front end for the system controller. Oversamples the async uart_rx line and deframes 8N1 bytes (8E1 with parity).

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo_if.sv | 19 +
 rtl/uart_byte_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive front end.
//   UART_DATA_BITS - data bits per frame
//   ST_* / uart_state_e - deframer state encoding
//   even_parity()  - value of the even-parity bit for a data byte
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP,
        S_BREAK  = ST_BREAK
    } uart_state_e;

    // Bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: received-byte stream from the UART front end to its consumer.
//   rx_data  - head byte, 8'h00 while rx_valid=0
//   rx_valid - a byte is offered
//   rx_ready - consumer accepts
// Handshake: a byte transfers in every cycle where rx_valid & rx_ready are both
// high at the rising clock edge. rx_valid/rx_data do not depend on rx_ready;
// rx_ready is ignored while rx_valid=0.
// Modports: master = byte source (the UART), slave = consumer.
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous show-ahead byte FIFO.
//   clk, rst   - clock, synchronous active-high reset
//   push/push_data - write request (ignored when full unless a pop happens too)
//   pop        - read request (ignored when empty)
//   head       - oldest byte, 8'h00 when empty
//   count      - bytes held; count_nxt is the value after this cycle's edge
//   full/empty - status
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] head,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH):0]    count_nxt,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic                      do_push;
    logic                      do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A pop on an empty FIFO does nothing; a push on a full FIFO only lands
    // when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign head      = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a show-ahead FIFO, with CTS flow control back to the host.
//   clk, rst    - system clock, synchronous active-high reset
//   uart_rx     - asynchronous serial input, idle high
//   uart_cts    - 1 = host may send (enough free FIFO entries)
//   rx_if       - byte stream to the consumer (master side)
//   fifo_count  - bytes held in the FIFO
//   frame_err   - sticky: stop bit sampled low
//   overflow    - sticky: completed byte dropped, FIFO full
//   parity_err  - sticky: parity mismatch (0 without UART_RX_PARITY_EN)
//   err_clr     - clears sticky flags (a same-cycle set wins)
//   fsm_state   - deframer state, encoded as uart_pkg ST_*
// Macro UART_RX_PARITY_EN: adds an even-parity bit after the data bits.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16,
    parameter int CTS_MARGIN   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         uart_rx,
    output logic                         uart_cts,
    uart_rx_fifo_if.master               rx_if,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         frame_err,
    output logic                         overflow,
    output logic                         parity_err,
    input  logic                         err_clr,
    output logic [2:0]                   fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    // Synchroniser; rxs_d is kept only to find the falling start edge.
    logic rx_meta;
    logic rxs;
    logic rxs_d;

    uart_state_e               state, state_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic [2:0]                bit_idx, bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
    logic                      push;
    logic                      frame_set;
    logic                      overflow_set;

    logic [AW:0] count_nxt;
    logic        fifo_full;
    logic        fifo_empty;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_set;
`endif

    // cnt counts clocks inside the current bit; each bit is sampled when it
    // reaches BIT_END, i.e. one bit-time after the mid-start-bit sample.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        push        = 1'b0;
        frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (rxs_d && !rxs) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == HALF_END) begin
                    cnt_nxt   = '0;
                    state_nxt = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rxs, shreg[UART_DATA_BITS-1:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_END) begin
                    cnt_nxt   = '0;
                    par_set   = (rxs != even_parity(shreg));
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        push      = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_nxt = '0;
                if (rxs) state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (rx_if.rx_ready),
        .head      (rx_if.rx_data),
        .count     (fifo_count),
        .count_nxt (count_nxt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_if.rx_valid = ~fifo_empty;

    // A byte is lost only when full and the head is not leaving this cycle.
    assign overflow_set = push & fifo_full & ~(rx_if.rx_ready & ~fifo_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            uart_cts  <= 1'b1;
        end else begin
            frame_err <= (frame_err & ~err_clr) | frame_set;
            overflow  <= (overflow & ~err_clr) | overflow_set;
            // Registered from next-state count so CTS tracks fifo_count exactly.
            uart_cts  <= ((FIFO_DEPTH - int'(count_nxt)) >= CTS_MARGIN);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= (parity_err & ~err_clr) | par_set;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed test of uart_rx_fifo with CLKS_PER_BIT=8,
// FIFO_DEPTH=4, CTS_MARGIN=2. Define UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx_fifo;

    localparam int CPB    = 8;
    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    localparam logic [2:0] T_IDLE  = 3'd0;
    localparam logic [2:0] T_START = 3'd1;
    localparam logic [2:0] T_DATA  = 3'd2;
    localparam logic [2:0] T_BREAK = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       uart_cts;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;
    logic       parity_err;
    logic       err_clr;
    logic [2:0] fsm_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo_if rx_if ();

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CTS_MARGIN   (MARGIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .uart_cts   (uart_cts),
        .rx_if      (rx_if.master),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .parity_err (parity_err),
        .err_clr    (err_clr),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    function automatic logic tb_even_par(input logic [7:0] d);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ d[i];
        return p;
    endfunction

    // Holds the line at b for one bit-time; call and return on a negedge.
    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, data LSB first, parity bit if built with parity. Returns at the
    // negedge where the stop bit should begin.
    task automatic send_head(input logic [7:0] d, input logic pb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pb);
`endif
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_head(d, tb_even_par(d));
        drive_bit(1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain_and_check(input string name);
        while (exp_q.size() > 0) begin
            checks++;
            if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== exp_q[0]) begin
                errors++;
                $display("FAIL %s pop valid/data got %b/%h want 1/%h", name,
                         rx_if.rx_valid, rx_if.rx_data, exp_q[0]);
            end
            rx_if.rx_ready = 1'b1;
            @(negedge clk);
            rx_if.rx_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        checks++;
        if (fifo_count !== 3'd0 || rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL %s drained count/valid/data got %0d/%b/%h want 0/0/00", name,
                     fifo_count, rx_if.rx_valid, rx_if.rx_data);
        end
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        uart_rx = 1'b1;
        err_clr = 1'b0;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset valid/data/count got %b/%h/%0d want 0/00/0",
                     rx_if.rx_valid, rx_if.rx_data, fifo_count);
        end
        checks++;
        if (uart_cts !== 1'b1 || frame_err !== 1'b0 || overflow !== 1'b0 ||
            parity_err !== 1'b0 || fsm_state !== T_IDLE) begin
            errors++;
            $display("FAIL reset cts/ferr/ovf/perr/state got %b/%b/%b/%b/%0d want 1/0/0/0/0",
                     uart_cts, frame_err, overflow, parity_err, fsm_state);
        end
    endtask

    task automatic test_single_byte();
        send_head(8'hA5, tb_even_par(8'hA5));
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (rx_if.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single early valid got %b want 0", rx_if.rx_valid);
        end
        @(negedge clk);
        checks++;
        if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'hA5 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL single push valid/data/count got %b/%h/%0d want 1/a5/1",
                     rx_if.rx_valid, rx_if.rx_data, fifo_count);
        end
        repeat (3) @(negedge clk);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
        checks++;
        if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single pop valid/data/count got %b/%h/%0d want 0/00/0",
                     rx_if.rx_valid, rx_if.rx_data, fifo_count);
        end
    endtask

    task automatic test_glitch();
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        checks++;
        if (fsm_state !== T_START) begin
            errors++;
            $display("FAIL glitch start state got %0d want %0d", fsm_state, T_START);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (fsm_state !== T_IDLE || fifo_count !== 3'd0 || rx_if.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch end state/count/valid got %0d/%0d/%b want 0/0/0",
                     fsm_state, fifo_count, rx_if.rx_valid);
        end
    endtask

    task automatic test_frame_error();
        send_head(8'h3C, tb_even_par(8'h3C));
        uart_rx = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || fsm_state !== T_BREAK || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL break ferr/state/count got %b/%0d/%0d want 1/5/0",
                     frame_err, fsm_state, fifo_count);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (fsm_state !== T_IDLE || fifo_count !== 3'd0 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL break exit state/count/ferr got %0d/%0d/%b want 0/0/1",
                     fsm_state, fifo_count, frame_err);
        end
        clear_errors();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err clear got %b want 0", frame_err);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_cnt [5];
        logic       exp_cts [5];
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_cts = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(i + 1));
            if (i < 4) exp_q.push_back(8'(i + 1));
            checks++;
            if (fifo_count !== exp_cnt[i] || uart_cts !== exp_cts[i] ||
                overflow !== (i == 4)) begin
                errors++;
                $display("FAIL fill byte %0d count/cts/ovf got %0d/%b/%b want %0d/%b/%b",
                         i + 1, fifo_count, uart_cts, overflow, exp_cnt[i], exp_cts[i], (i == 4));
            end
        end
        drain_and_check("overflow");
        checks++;
        if (uart_cts !== 1'b1) begin
            errors++;
            $display("FAIL overflow drained cts got %b want 1", uart_cts);
        end
        // Pops on an empty FIFO must not wrap the count.
        rx_if.rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rx_if.rx_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || rx_if.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty pop count/valid got %0d/%b want 0/0", fifo_count, rx_if.rx_valid);
        end
        clear_errors();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow clear got %b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full count/ovf got %0d/%b want 4/0", fifo_count, overflow);
        end
        // Pop exactly in the cycle that pushes 8'h14.
        send_head(8'h14, tb_even_par(8'h14));
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h14);
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || rx_if.rx_data !== 8'h11) begin
            errors++;
            $display("FAIL full push+pop count/ovf/head got %0d/%b/%h want 4/0/11",
                     fifo_count, overflow, rx_if.rx_data);
        end
        repeat (3) @(negedge clk);
        drain_and_check("full_push_pop");
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_head(8'h07, 1'b1);
        drive_bit(1'b1);
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h07);
        checks++;
        if (parity_err !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL parity good perr/count got %b/%0d want 0/1", parity_err, fifo_count);
        end
        send_head(8'h07, 1'b0);
        drive_bit(1'b1);
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h07);
        checks++;
        if (parity_err !== 1'b1 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL parity bad perr/count got %b/%0d want 1/2", parity_err, fifo_count);
        end
        drain_and_check("parity");
        clear_errors();
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity clear got %b want 0", parity_err);
        end
`else
        send_byte(8'h07);
        exp_q.push_back(8'h07);
        checks++;
        if (parity_err !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL no-parity perr/count got %b/%0d want 0/1", parity_err, fifo_count);
        end
        drain_and_check("no_parity");
`endif
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h5A);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        checks++;
        if (fsm_state !== T_DATA || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL mid-frame state/count got %0d/%0d want 2/1", fsm_state, fifo_count);
        end
        rst = 1'b1;
        uart_rx = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 || fifo_count !== 3'd0 ||
            uart_cts !== 1'b1 || fsm_state !== T_IDLE || frame_err !== 1'b0 ||
            overflow !== 1'b0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL mid-frame reset valid/data/count/cts/state got %b/%h/%0d/%b/%0d want 0/00/0/1/0",
                     rx_if.rx_valid, rx_if.rx_data, fifo_count, uart_cts, fsm_state);
        end
        rst = 1'b0;
        repeat (10 * CPB) @(negedge clk);
        checks++;
        if (fsm_state !== T_IDLE || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL post-reset state/count got %0d/%0d want 0/0", fsm_state, fifo_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_full_push_pop();
        test_parity();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
